// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared types and helpers for the encrypt round controller:
//               FSM state encoding, round-counter width and the expansion
//               permutation used by the round function.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  // Two-bit state register; the fourth code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Wide enough to count up to the largest legal round count (15).
  localparam int unsigned CNT_W = 4;

  // Expansion permutation: spreads the low data nibble over a full byte.
  // Only d[3:0] participates, so only that nibble is passed in.
  function automatic logic [7:0] expand(input logic [3:0] n);
    return {n[3], n[0], n[1], n[2], n[1], n[3], n[2], n[0]};
  endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/encrypt_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_round_ctrl_if
// Description : Input/output handshake bundle of the encrypt round controller.
//   in_valid   : number/key are valid (producer -> block)
//   in_ready   : block can accept a new byte (block -> producer)
//   number     : 8-bit plaintext byte
//   key        : 8-bit initial round key
//   out_valid  : enc_number is valid (block -> consumer)
//   out_ready  : consumer accepts the result (consumer -> block)
//   enc_number : 8-bit ciphertext byte
//   busy       : block is in ROUND or DONE
//   Modports   : slave = the controller, master = producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface encrypt_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number;
  logic [7:0] key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] enc_number;
  logic       busy;

  modport slave (
    input  in_valid, number, key, out_ready,
    output in_ready, out_valid, enc_number, busy
  );

  modport master (
    output in_valid, number, key, out_ready,
    input  in_ready, out_valid, enc_number, busy
  );
endinterface : encrypt_round_ctrl_if
`default_nettype wire

// File: rtl/enc_round_fn.sv
`default_nettype none
// ============================================================================
// Module      : enc_round_fn
// Description : Purely combinational single encryption round.
//   d : 8-bit data in
//   k : 8-bit round key
//   q : 8-bit data after one round
// Revision    : 1.0 - initial release
// ============================================================================
module enc_round_fn
  import enc_pkg::*;
(
  input  logic [7:0] d,
  input  logic [7:0] k,
  output logic [7:0] q
);

  logic [7:0] mix;
  logic [3:0] sbox;

  assign mix  = expand(d[3:0]) ^ k;
  // 4-bit sum: the carry out of the nibble add is deliberately dropped.
  assign sbox = mix[7:4] + mix[3:0] + {3'b000, k[0]};
  // Feistel-like swap: low nibble moves up, high nibble is masked by sbox.
  assign q    = {d[3:0], d[7:4] ^ sbox};

endmodule : enc_round_fn
`default_nettype wire

// File: rtl/encrypt_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_round_ctrl
// Description : Iterative byte cipher controller. Accepts a plaintext byte
//               and key, applies ROUNDS rounds (one per clock) and holds the
//               ciphertext until the consumer takes it.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : encrypt_round_ctrl_if.slave handshake bundle
//   ROUNDS: rounds per block, legal range 1..15 (default 4)
//   Macro ENC_CTRL_KEY_ROTATE_EN: when defined the key rotates left one
//   bit after every round; otherwise the accepted key is used throughout.
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_round_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned ROUNDS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  encrypt_round_ctrl_if.slave   bus
);

  // Counter value held during the final round.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       data_q;
  logic [7:0]       key_q;
  logic [7:0]       data_d;
  logic [7:0]       key_d;

  enc_round_fn u_round (
    .d (data_q),
    .k (key_q),
    .q (data_d)
  );

`ifdef ENC_CTRL_KEY_ROTATE_EN
  assign key_d = {key_q[6:0], key_q[7]};
`else
  assign key_d = key_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      key_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          // Inputs are only sampled here, so in_valid outside IDLE is inert.
          if (bus.in_valid) begin
            data_q  <= bus.number;
            key_q   <= bus.key;
            cnt_q   <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          data_q <= data_d;
          key_q  <= key_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Going back through IDLE keeps accept and output in separate cycles.
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags are decoded from the state register only.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q == ROUND) || (state_q == DONE);
  assign bus.enc_number = data_q;

endmodule : encrypt_round_ctrl
`default_nettype wire

// File: tb/tb_encrypt_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_encrypt_round_ctrl
// Description : Self-checking bench for encrypt_round_ctrl. Three instances
//               (ROUNDS = 1, 2, 4) share one clock; each has its own reset
//               and a scoreboard queue of expected ciphertext bytes that a
//               monitor pops whenever a result is handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encrypt_round_ctrl;

  logic clock = 1'b0;
  logic rst1, rst2, rst4;

  always #5 clock = ~clock;

  encrypt_round_ctrl_if if1 ();
  encrypt_round_ctrl_if if2 ();
  encrypt_round_ctrl_if if4 ();

  encrypt_round_ctrl #(.ROUNDS(1)) u_dut1 (.clock(clock), .reset(rst1), .bus(if1.slave));
  encrypt_round_ctrl #(.ROUNDS(2)) u_dut2 (.clock(clock), .reset(rst2), .bus(if2.slave));
  encrypt_round_ctrl #(.ROUNDS(4)) u_dut4 (.clock(clock), .reset(rst4), .bus(if4.slave));

  int total = 0;
  int bad   = 0;

  logic [7:0] exp1[$];
  logic [7:0] exp2[$];
  logic [7:0] exp4[$];

`ifdef ENC_CTRL_KEY_ROTATE_EN
  localparam logic [7:0] EXP_R2 = 8'h0C;
  localparam logic [7:0] EXP_R4 = 8'h57;
`else
  localparam logic [7:0] EXP_R2 = 8'h0B;
  localparam logic [7:0] EXP_R4 = 8'h6F;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] act);
    total++;
    bad++;
    $display("FAIL %s: got output %0h expected none", name, act);
  endtask

  // Monitors: a result is consumed when out_valid and out_ready are both high.
  always @(negedge clock) begin
    if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      if (exp1.size() == 0) unexpected("r1_unexpected", if1.enc_number);
      else check("r1_result", if1.enc_number, exp1.pop_front());
    end
  end

  always @(negedge clock) begin
    if (if2.out_valid === 1'b1 && if2.out_ready === 1'b1) begin
      if (exp2.size() == 0) unexpected("r2_unexpected", if2.enc_number);
      else check("r2_result", if2.enc_number, exp2.pop_front());
    end
  end

  always @(negedge clock) begin
    if (if4.out_valid === 1'b1 && if4.out_ready === 1'b1) begin
      if (exp4.size() == 0) unexpected("r4_unexpected", if4.enc_number);
      else check("r4_result", if4.enc_number, exp4.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic out_v(input int w);
    case (w)
      1:       return if1.out_valid;
      2:       return if2.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  function automatic logic in_r(input int w);
    case (w)
      1:       return if1.in_ready;
      2:       return if2.in_ready;
      default: return if4.in_ready;
    endcase
  endfunction

  // One-cycle accept: checks in_ready, presents the byte for one edge.
  task automatic send(input int w, input logic [7:0] n, input logic [7:0] k);
    check("accept_ready", in_r(w), 1'b1);
    case (w)
      1:       begin if1.number = n; if1.key = k; if1.in_valid = 1'b1; end
      2:       begin if2.number = n; if2.key = k; if2.in_valid = 1'b1; end
      default: begin if4.number = n; if4.key = k; if4.in_valid = 1'b1; end
    endcase
    tick();
    case (w)
      1:       if1.in_valid = 1'b0;
      2:       if2.in_valid = 1'b0;
      default: if4.in_valid = 1'b0;
    endcase
  endtask

  // Counts edges after the accept until out_valid; stops at the budget.
  task automatic wait_valid(input int w, input int budget, output int cycles);
    cycles = 0;
    while (out_v(w) !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
    if1.in_valid = 1'b0; if1.number = 8'h00; if1.key = 8'h00; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.number = 8'h00; if2.key = 8'h00; if2.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.number = 8'h00; if4.key = 8'h00; if4.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_in_ready",  if1.in_ready,   1'b1);
    check("rst_out_valid", if1.out_valid,  1'b0);
    check("rst_busy",      if1.busy,       1'b0);
    check("rst_enc",       if1.enc_number, 8'h00);
    check("rst4_in_ready", if4.in_ready,   1'b1);
    check("rst2_busy",     if2.busy,       1'b0);
    rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;

    // ROUNDS=1: 46/93 -> 60 on the next edge
    exp1.push_back(8'h60);
    send(1, 8'h46, 8'h93);
    check("r1_busy_round", if1.busy,     1'b1);
    check("r1_noready",    if1.in_ready, 1'b0);
    wait_valid(1, 10, lat);
    check("r1_latency", lat, 1);
    tick();
    check("r1_back_idle", if1.in_ready, 1'b1);

    // ROUNDS=1: C9/AC -> 93
    exp1.push_back(8'h93);
    send(1, 8'hC9, 8'hAC);
    wait_valid(1, 10, lat);
    check("r1b_latency", lat, 1);
    tick();

    // ROUNDS=2: 46/93 -> 0B (fixed key) or 0C (rotating key)
    exp2.push_back(EXP_R2);
    send(2, 8'h46, 8'h93);
    wait_valid(2, 10, lat);
    check("r2_latency", lat, 2);
    tick();

    // Backpressure on ROUNDS=1: result held, inputs ignored in DONE
    if1.out_ready = 1'b0;
    exp1.push_back(8'h60);
    send(1, 8'h46, 8'h93);
    wait_valid(1, 10, lat);
    check("bp_latency", lat, 1);
    if1.number = 8'hFF;
    if1.key    = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      if1.in_valid = ~if1.in_valid;
      tick();
      check("bp_enc_stable", if1.enc_number, 8'h60);
      check("bp_in_ready",   if1.in_ready,   1'b0);
      check("bp_out_valid",  if1.out_valid,  1'b1);
    end
    if1.in_valid  = 1'b1;
    if1.number    = 8'hC9;
    if1.key       = 8'hAC;
    if1.out_ready = 1'b1;
    tick();
    check("bp_idle_ready", if1.in_ready,  1'b1);
    check("bp_idle_ov",    if1.out_valid, 1'b0);
    exp1.push_back(8'h93);
    tick();
    if1.in_valid = 1'b0;
    check("bp_reaccept_busy", if1.busy, 1'b1);
    wait_valid(1, 10, lat);
    check("bp_reaccept_lat", lat, 1);
    tick();

    // ROUNDS=4: reset mid-ROUND discards the block
    send(4, 8'h46, 8'h93);
    tick();
    check("r4_midround_busy", if4.busy, 1'b1);
    rst4 = 1'b1;
    #1;
    check("r4_rst_in_ready",  if4.in_ready,   1'b1);
    check("r4_rst_out_valid", if4.out_valid,  1'b0);
    check("r4_rst_busy",      if4.busy,       1'b0);
    check("r4_rst_enc",       if4.enc_number, 8'h00);
    tick();
    rst4 = 1'b0;

    // Fresh accept on the first edge after release
    exp4.push_back(EXP_R4);
    send(4, 8'h46, 8'h93);
    wait_valid(4, 12, lat);
    check("r4_latency", lat, 4);
    tick();
    tick();

    check("sb1_drained", exp1.size(), 0);
    check("sb2_drained", exp2.size(), 0);
    check("sb4_drained", exp4.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_encrypt_round_ctrl
`default_nettype wire
